cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint sequencer for the CPU core; replaces the free-running divided CPU clocks.
- Runs on the board clock and emits a one-cycle clock-enable pulse (cpu_ce) per CPU tick.
- Modes: free-run at a selectable rate, single-step from a button, halt, and stop on a PC breakpoint.
- Exports a tick counter and status flags for the 7-segment display path.

Parameters:
- TICK_DIV, 100000000: board-clock cycles per CPU tick at rate_sel=0; must be a multiple of 16 and >= 16.
- CNT_W, 32: width of tick_count.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run_btn  input  1  asynchronous button; a rising edge requests RUN.
- step_btn  input  1  asynchronous button; a rising edge requests one CPU tick.
- halt_btn  input  1  asynchronous button; a rising edge requests HALT.
- rate_sel  input  2  tick period: 0=TICK_DIV, 1=TICK_DIV/4, 2=TICK_DIV/16, 3=1 (every clk).
- bp_en  input  1  breakpoint enable.
- bp_addr  input  32  breakpoint PC.
- pc  input  32  current CPU PC, synchronous to clk, stable between cpu_ce pulses.
- cpu_ce  output  1  one-clk-wide CPU tick enable.
- running  output  1  1 while in RUN.
- bp_hit  output  1  1 while in BREAK.
- tick_count  output  CNT_W  number of cpu_ce pulses issued.

Behaviour:
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then rising-edge detection.
  - An edge event (run_ev/step_ev/halt_ev) is valid 3 clk after the pin rises and lasts 1 clk.
  - Priority for simultaneous events: halt_ev > step_ev > run_ev.
- Reset (async, immediate) values:
  - state=HALT; cpu_ce=0, running=0, bp_hit=0, tick_count=0.
  - Divider and all synchronizer/edge flops = 0. No pulse is emitted during or on release of reset.
- States: HALT, RUN, STEP, BREAK.
- HALT:
  - step_ev -> STEP.
  - run_ev -> RUN; divider cleared.
  - halt_ev: no effect.
- STEP:
  - Lasts exactly 1 clk with cpu_ce=1, then -> HALT.
  - No breakpoint check. Events arriving during STEP are dropped.
- RUN:
  - Divider counts 0..P-1, where P is the period chosen by rate_sel.
  - On the cycle the divider is >= P-1 (fire condition), the divider returns to 0.
    - Normally cpu_ce=1 that cycle.
    - If bp_en=1 and pc==bp_addr and the skip flag is clear: no pulse, go to BREAK.
  - halt_ev -> HALT with no pulse that cycle, even if the fire condition holds.
  - step_ev in RUN: ignored.
  - rate_sel may change at any time. The >= compare guarantees a pulse no later than the next cycle if the divider already exceeds the new P-1.
  - P=1 (rate_sel=3): the fire condition holds every clk, so cpu_ce is continuous.
- BREAK:
  - cpu_ce held 0.
  - run_ev -> RUN, divider cleared, skip flag set.
  - step_ev -> STEP.
  - halt_ev -> HALT.
- Skip flag:
  - Suppresses the breakpoint check for the first fire in RUN after leaving BREAK, so execution can move past the breakpoint.
  - Cleared on that fire, on halt, and on reset.
- Outputs:
  - cpu_ce, running and bp_hit are registered, decoded from the next state, so they align with the state register.
  - tick_count increments on every cycle with cpu_ce=1 and wraps from 2^CNT_W-1 to 0.
- Reset mid-pulse: cpu_ce drops immediately; tick_count=0.

Test Plan (TICK_DIV=16 in sim):
- Reset, then run_btn pulse, rate_sel=0 -> running=1 4 clk after the pin rises; cpu_ce pulses every 16 clk; tick_count=3 after 3 pulses.
- In HALT, step_btn pulse 3 times, spaced 10 clk -> exactly 3 single-clk cpu_ce pulses; tick_count=3; running stays 0.
- RUN with rate_sel=3, bp_en=1, bp_addr=0x0000_0010, pc driven =0x10 at the 5th tick -> 4 pulses, then bp_hit=1 with no 5th pulse. A run_btn pulse then yields a pulse within 1 clk; bp_hit=0.
- halt_btn and run_btn rise on the same clk during RUN -> HALT, running=0, no cpu_ce on the event cycle.
- RUN with rate_sel=0, divider at 10, switch rate_sel to 2 (P=1) -> cpu_ce on the next clk, then every clk.
- tick_count preset near wrap (CNT_W=4, 15 pulses, then 1 more) -> reads 0xF then 0x0. Assert rst mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: turns the board clock into one-cycle CPU clock
// enables, with free-run at a selectable rate, single-step, halt and PC breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_btn,
    input  logic [1:0]       rate_sel,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             cpu_ce,
    output logic             running,
    output logic             bp_hit,
    output logic [CNT_W-1:0] tick_count,
    output logic [1:0]       dbg_state
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] PM1_FULL    = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] PM1_QUARTER = DIV_W'(TICK_DIV / 4 - 1);
    localparam logic [DIV_W-1:0] PM1_SIXTEEN = DIV_W'(TICK_DIV / 16 - 1);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_BREAK = 2'd3;

    // Button bit order: [0]=run, [1]=step, [2]=halt.
    logic [2:0] sync0_q;
    logic [2:0] sync1_q;
    logic [2:0] prev_q;
    logic [2:0] ev_q;

    logic             run_ev;
    logic             step_ev;
    logic             halt_ev;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             skip_q, skip_d;
    logic             ce_q, ce_d;
    logic             running_q;
    logic             bp_hit_q;
    logic [CNT_W-1:0] count_q;

    logic [DIV_W-1:0] pm1;
    logic             fire;
    logic             bp_match;

    // The edge is registered so an event appears 3 clk after the pin rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
        end else begin
            sync0_q <= {halt_btn, step_btn, run_btn};
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
            ev_q    <= sync1_q & ~prev_q;
        end
    end

    assign run_ev  = ev_q[0];
    assign step_ev = ev_q[1];
    assign halt_ev = ev_q[2];

    always_comb begin
        pm1 = PM1_FULL;
        case (rate_sel)
            2'd0:    pm1 = PM1_FULL;
            2'd1:    pm1 = PM1_QUARTER;
            2'd2:    pm1 = PM1_SIXTEEN;
            default: pm1 = '0;
        endcase
    end

    // >= rather than == so a shortened period fires at once when the divider is already past it.
    assign fire     = (div_q >= pm1);
    assign bp_match = bp_en && (pc == bp_addr);

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        skip_d  = skip_q;
        ce_d    = 1'b0;
        case (state_q)
            S_HALT: begin
                if (!halt_ev && step_ev) begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end else if (!halt_ev && run_ev) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            S_RUN: begin
                if (halt_ev) begin
                    state_d = S_HALT;
                end else if (fire) begin
                    if (bp_match && !skip_q) begin
                        state_d = S_BREAK;
                    end else begin
                        ce_d   = 1'b1;
                        skip_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_BREAK: begin
                if (halt_ev) begin
                    state_d = S_HALT;
                end else if (step_ev) begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end else if (run_ev) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        if (state_d == S_HALT) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HALT;
            div_q     <= '0;
            skip_q    <= 1'b0;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            skip_q    <= skip_d;
            ce_q      <= ce_d;
            running_q <= (state_d == S_RUN);
            bp_hit_q  <= (state_d == S_BREAK);
            if (ce_d) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign cpu_ce     = ce_q;
    assign running    = running_q;
    assign bp_hit     = bp_hit_q;
    assign tick_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected tick_count values are queued when a pulse
// is provoked and checked by a negedge monitor when the pulse appears.
module tb_cpu_run_ctrl;

    localparam int unsigned TICK_DIV = 16;
    localparam int unsigned CNT_W    = 4;

    logic             clk;
    logic             rst;
    logic             run_btn;
    logic             step_btn;
    logic             halt_btn;
    logic [1:0]       rate_sel;
    logic             bp_en;
    logic [31:0]      bp_addr;
    logic [31:0]      pc;
    logic             cpu_ce;
    logic             running;
    logic             bp_hit;
    logic [CNT_W-1:0] tick_count;
    logic [1:0]       dbg_state;

    logic [CNT_W-1:0] exp_q[$];
    int checks;
    int errors;
    int pulse_cnt;
    int cyc;
    int last_t;
    int prev_t;
    int n_ce;

    cpu_run_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt_btn   (halt_btn),
        .rate_sel   (rate_sel),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_ce     (cpu_ce),
        .running    (running),
        .bp_hit     (bp_hit),
        .tick_count (tick_count),
        .dbg_state  (dbg_state)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor: every cpu_ce cycle consumes one expected tick_count
    initial begin
        pulse_cnt = 0;
        last_t    = 0;
        prev_t    = 0;
    end

    always @(negedge clk) begin
        if (cpu_ce === 1'b1) begin
            pulse_cnt++;
            prev_t = last_t;
            last_t = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed tick_count=%0h expected no pulse", tick_count);
            end
            if (exp_q.size() != 0) begin
                check("pulse_tick_count", 32'(tick_count), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_run();
        run_btn = 1'b1;
        tick();
        tick();
        run_btn = 1'b0;
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        tick();
        tick();
        step_btn = 1'b0;
        repeat (8) tick();
    endtask

    task automatic wait_running(input string tag);
        for (int i = 0; i < 10 && running !== 1'b1; i++) tick();
        check(tag, 32'(running), 1);
    endtask

    task automatic do_reset();
        check("leftover_expected", 32'(exp_q.size()), 0);
        rst      = 1'b1;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
        rate_sel = 2'd0;
        bp_en    = 1'b0;
        pc       = 32'h0;
        tick();
        tick();
        rst       = 1'b0;
        pulse_cnt = 0;
        exp_q.delete();
        tick();
        tick();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
        rate_sel = 2'd0;
        bp_en    = 1'b0;
        bp_addr  = 32'h0;
        pc       = 32'h0;
        #2;
        check("rst_cpu_ce", 32'(cpu_ce), 0);
        check("rst_running", 32'(running), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        check("rst_tick_count", 32'(tick_count), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_running", 32'(running), 0);
        check("post_rst_cpu_ce", 32'(cpu_ce), 0);

        // free run at the slowest rate
        run_btn = 1'b1;
        tick();
        tick();
        tick();
        check("run_latency_3clk", 32'(running), 0);
        tick();
        check("run_latency_4clk", 32'(running), 1);
        run_btn = 1'b0;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        for (int i = 0; i < 80 && pulse_cnt < 3; i++) tick();
        check("run_pulse_count", 32'(pulse_cnt), 3);
        check("run_period", 32'(last_t - prev_t), 16);
        check("run_tick_count", 32'(tick_count), 3);
        do_reset();

        // single steps from HALT
        for (int n = 1; n <= 3; n++) begin
            exp_q.push_back(4'(n));
            press_step();
            check("step_running", 32'(running), 0);
        end
        check("step_pulse_count", 32'(pulse_cnt), 3);
        check("step_tick_count", 32'(tick_count), 3);
        do_reset();

        // breakpoint at the 5th tick, then resume past it
        rate_sel = 2'd3;
        bp_en    = 1'b1;
        bp_addr  = 32'h0000_0010;
        for (int n = 1; n <= 4; n++) exp_q.push_back(4'(n));
        press_run();
        wait_running("bp_enter_run");
        n_ce = 0;
        for (int i = 0; i < 10 && n_ce < 4; i++) begin
            tick();
            if (cpu_ce === 1'b1) n_ce++;
        end
        check("bp_pre_pulses", 32'(n_ce), 4);
        pc = 32'h0000_0010;
        tick();
        tick();
        tick();
        check("bp_hit_set", 32'(bp_hit), 1);
        check("bp_running_clr", 32'(running), 0);
        check("bp_no_fifth", 32'(pulse_cnt), 4);
        check("bp_tick_count", 32'(tick_count), 4);
        exp_q.push_back(4'd5);
        press_run();
        wait_running("bp_resume_run");
        check("bp_resume_hit_clr", 32'(bp_hit), 0);
        tick();
        check("bp_resume_pulse", 32'(cpu_ce), 1);
        tick();
        check("bp_rebreak", 32'(bp_hit), 1);
        check("bp_rebreak_ce", 32'(cpu_ce), 0);
        check("bp_resume_count", 32'(pulse_cnt), 5);
        do_reset();

        // halt and run on the same clk during RUN: halt wins
        rate_sel = 2'd3;
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        press_run();
        wait_running("prio_enter_run");
        halt_btn = 1'b1;
        run_btn  = 1'b1;
        tick();
        tick();
        tick();
        check("prio_still_running", 32'(running), 1);
        tick();
        check("prio_halted", 32'(running), 0);
        check("prio_no_ce", 32'(cpu_ce), 0);
        halt_btn = 1'b0;
        run_btn  = 1'b0;
        repeat (6) tick();
        check("prio_stays_halt", 32'(running), 0);
        check("prio_pulse_count", 32'(pulse_cnt), 3);
        do_reset();

        // rate change mid-period with the divider already past the new period
        rate_sel = 2'd0;
        press_run();
        wait_running("rate_enter_run");
        repeat (10) tick();
        rate_sel = 2'd2;
        check("rate_no_early_ce", 32'(cpu_ce), 0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        tick();
        check("rate_ce_1", 32'(cpu_ce), 1);
        tick();
        check("rate_ce_2", 32'(cpu_ce), 1);
        tick();
        check("rate_ce_3", 32'(cpu_ce), 1);
        rate_sel = 2'd0;
        repeat (4) tick();
        check("rate_pulse_count", 32'(pulse_cnt), 3);
        check("rate_tick_count", 32'(tick_count), 3);
        do_reset();

        // tick_count wrap with a 4-bit counter
        for (int n = 1; n <= 16; n++) begin
            exp_q.push_back(4'(n));
            press_step();
            if (n == 15) check("wrap_at_f", 32'(tick_count), 32'hF);
        end
        check("wrap_to_0", 32'(tick_count), 0);

        // asynchronous reset in the middle of continuous RUN
        rate_sel = 2'd3;
        exp_q.push_back(4'd1);
        press_run();
        wait_running("arst_enter_run");
        tick();
        tick();
        check("arst_pre_ce", 32'(cpu_ce), 1);
        check("arst_pre_count", 32'(tick_count), 2);
        rst = 1'b1;
        #1;
        check("arst_cpu_ce", 32'(cpu_ce), 0);
        check("arst_running", 32'(running), 0);
        check("arst_bp_hit", 32'(bp_hit), 0);
        check("arst_tick_count", 32'(tick_count), 0);
        tick();
        tick();
        rst = 1'b0;
        rate_sel = 2'd0;
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
